// File: rtl/packet_parity_checker.sv
// Packet parity checker: recomputes per-word parity, accumulates per-packet
// length, error count and column parity, and emits one record per packet.

module nbit_xor #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_data,
  output logic         o_par
);

  logic w_acc;

  always_comb begin
    w_acc = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_acc = w_acc ^ i_data[k];
    end
  end

  assign o_par = w_acc;

endmodule

module packet_parity_checker #(
  parameter int N   = 8,
  parameter int CW  = 4,
  parameter int ODD = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_par,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_len,
  output logic [CW-1:0] out_errs,
  output logic [N-1:0]  out_colpar,
  output logic          out_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_REPORT
  } state_t;

  localparam logic [CW-1:0] MAX = '1;
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        r_state;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_errs;
  logic [N-1:0]  r_col;
  logic [CW-1:0] r_out_len;
  logic [CW-1:0] r_out_errs;
  logic [N-1:0]  r_out_col;
  logic          r_out_err;

  logic          w_par;
  logic          w_odd;
  logic          w_mis;
  logic          w_accept;
  logic [CW-1:0] w_len_n;
  logic [CW-1:0] w_errs_n;
  logic [N-1:0]  w_col_n;

  nbit_xor #(
    .N(N)
  ) u_xor (
    .i_data(in_data),
    .o_par (w_par)
  );

  assign w_odd    = (ODD != 0);
  assign w_mis    = (w_par ^ w_odd) != in_par;
  assign w_accept = in_valid & r_in_ready;

  // First word of a packet loads the accumulators; later words fold in.
  always_comb begin
    w_len_n  = ONE;
    w_errs_n = w_mis ? ONE : '0;
    w_col_n  = in_data;
    if (r_state == S_ACCUM) begin
      w_len_n  = (r_len == MAX) ? r_len : r_len + ONE;
      w_errs_n = (w_mis && r_errs != MAX) ? r_errs + ONE : r_errs;
      w_col_n  = r_col ^ in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_len       <= '0;
      r_errs      <= '0;
      r_col       <= '0;
      r_out_len   <= '0;
      r_out_errs  <= '0;
      r_out_col   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_len  <= w_len_n;
            r_errs <= w_errs_n;
            r_col  <= w_col_n;
            if (in_last) begin
              r_state     <= S_REPORT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_len   <= w_len_n;
              r_out_errs  <= w_errs_n;
              r_out_col   <= w_col_n;
              r_out_err   <= (w_errs_n != '0);
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_REPORT: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_len    = r_out_len;
  assign out_errs   = r_out_errs;
  assign out_colpar = r_out_col;
  assign out_err    = r_out_err;

endmodule

// File: tb/tb_packet_parity_checker.sv
// Directed bench for packet_parity_checker: an even-parity and an
// odd-parity instance share one input stream.

module tb_packet_parity_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_par = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_len;
  logic [3:0] out_errs;
  logic [7:0] out_colpar;
  logic       out_err;

  logic       o_in_ready;
  logic       o_out_valid;
  logic [3:0] o_out_len;
  logic [3:0] o_out_errs;
  logic [7:0] o_out_colpar;
  logic       o_out_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  packet_parity_checker #(.N(8), .CW(4), .ODD(0)) dut_e (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_par    (in_par),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_len   (out_len),
    .out_errs  (out_errs),
    .out_colpar(out_colpar),
    .out_err   (out_err)
  );

  packet_parity_checker #(.N(8), .CW(4), .ODD(1)) dut_o (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (o_in_ready),
    .in_data   (in_data),
    .in_par    (in_par),
    .in_last   (in_last),
    .out_valid (o_out_valid),
    .out_ready (out_ready),
    .out_len   (o_out_len),
    .out_errs  (o_out_errs),
    .out_colpar(o_out_colpar),
    .out_err   (o_out_err)
  );

  task automatic send(input logic [7:0] d, input logic p, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL consume: valid,ready=%b required 01",
               {out_valid, in_ready});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, in_ready, out_len, out_errs, out_colpar, out_err}
        !== 19'd0) begin
      miscompares++;
      $display("FAIL reset: got %h required 0",
               {out_valid, in_ready, out_len, out_errs, out_colpar, out_err});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send(8'hA5, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_gap: out_valid=%b required 0", out_valid);
    end
    send(8'h01, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b1);
    vectors++;
    if ({out_valid, out_len, out_errs, out_colpar, out_err}
        !== {1'b1, 4'd3, 4'd0, 8'h5B, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_rec: got %h required %h",
               {out_valid, out_len, out_errs, out_colpar, out_err},
               {1'b1, 4'd3, 4'd0, 8'h5B, 1'b0});
    end
    consume();
  endtask

  task automatic test_errors();
    send(8'h03, 1'b1, 1'b0);
    send(8'h80, 1'b0, 1'b1);
    vectors++;
    if ({out_valid, out_len, out_errs, out_colpar, out_err}
        !== {1'b1, 4'd2, 4'd2, 8'h83, 1'b1}) begin
      miscompares++;
      $display("FAIL errors_even: got %h required %h",
               {out_valid, out_len, out_errs, out_colpar, out_err},
               {1'b1, 4'd2, 4'd2, 8'h83, 1'b1});
    end
    vectors++;
    if ({o_out_valid, o_out_len, o_out_errs, o_out_colpar, o_out_err}
        !== {1'b1, 4'd2, 4'd0, 8'h83, 1'b0}) begin
      miscompares++;
      $display("FAIL errors_odd: got %h required %h",
               {o_out_valid, o_out_len, o_out_errs, o_out_colpar, o_out_err},
               {1'b1, 4'd2, 4'd0, 8'h83, 1'b0});
    end
    consume();
  endtask

  task automatic test_backpressure();
    send(8'h3C, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_par   = 1'b0;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({in_ready, out_valid, out_len, out_errs, out_colpar, out_err}
          !== {1'b0, 1'b1, 4'd1, 4'd0, 8'h3C, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got %h required %h", i,
                 {in_ready, out_valid, out_len, out_errs, out_colpar, out_err},
                 {1'b0, 1'b1, 4'd1, 4'd0, 8'h3C, 1'b0});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_release: valid,ready=%b required 01",
               {out_valid, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    vectors++;
    if ({out_valid, out_len, out_errs, out_colpar, out_err}
        !== {1'b1, 4'd1, 4'd0, 8'h5A, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_held_word: got %h required %h",
               {out_valid, out_len, out_errs, out_colpar, out_err},
               {1'b1, 4'd1, 4'd0, 8'h5A, 1'b0});
    end
    consume();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      send(8'h01, 1'b1, (i == 19));
    end
    vectors++;
    if ({out_valid, out_len, out_errs, out_colpar, out_err}
        !== {1'b1, 4'd15, 4'd0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL sat_even: got %h required %h",
               {out_valid, out_len, out_errs, out_colpar, out_err},
               {1'b1, 4'd15, 4'd0, 8'h00, 1'b0});
    end
    vectors++;
    if ({o_out_valid, o_out_len, o_out_errs, o_out_colpar, o_out_err}
        !== {1'b1, 4'd15, 4'd15, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL sat_odd: got %h required %h",
               {o_out_valid, o_out_len, o_out_errs, o_out_colpar, o_out_err},
               {1'b1, 4'd15, 4'd15, 8'h00, 1'b1});
    end
    consume();
  endtask

  task automatic test_reset_mid();
    send(8'hA5, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if ({out_valid, in_ready, out_len, out_colpar} !== 14'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got %h required 0",
               {out_valid, in_ready, out_len, out_colpar});
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_rec: out_valid=%b required 0", out_valid);
    end
    send(8'h07, 1'b1, 1'b1);
    vectors++;
    if ({out_valid, out_len, out_errs, out_colpar, out_err}
        !== {1'b1, 4'd1, 4'd0, 8'h07, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_next: got %h required %h",
               {out_valid, out_len, out_errs, out_colpar, out_err},
               {1'b1, 4'd1, 4'd0, 8'h07, 1'b0});
    end
    consume();
  endtask

  task automatic test_odd();
    send(8'h00, 1'b1, 1'b1);
    vectors++;
    if ({o_out_valid, o_out_len, o_out_errs, o_out_err}
        !== {1'b1, 4'd1, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL odd_ok: got %h required %h",
               {o_out_valid, o_out_len, o_out_errs, o_out_err},
               {1'b1, 4'd1, 4'd0, 1'b0});
    end
    vectors++;
    if ({out_errs, out_err} !== {4'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL odd_even_ref: got %h required %h",
               {out_errs, out_err}, {4'd1, 1'b1});
    end
    consume();
    send(8'h00, 1'b0, 1'b1);
    vectors++;
    if ({o_out_valid, o_out_len, o_out_errs, o_out_err}
        !== {1'b1, 4'd1, 4'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL odd_bad: got %h required %h",
               {o_out_valid, o_out_len, o_out_errs, o_out_err},
               {1'b1, 4'd1, 4'd1, 1'b1});
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    test_odd();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
